// File: rtl/taxi_i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
package taxi_i2c_target_pkg;

  // Bit counter spans 0..8 (eight data bits plus a terminal count).
  localparam int unsigned BitCntW = 4;

  // Position of the R/W flag inside the received address byte.
  localparam int unsigned RwBit = 0;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } state_e;

endpackage

// File: rtl/taxi_i2c_target_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample glitch filter for one pin.
// The filtered level only changes after FILTER_LEN consecutive differing samples.
module taxi_i2c_target_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level
);

  localparam int unsigned CntW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [CntW-1:0] r_cnt;

  // Synchronize the pin, then count consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(FILTER_LEN - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/taxi_i2c_target.sv
// I2C target exposing a byte-wide register file with an auto-incrementing pointer.
// Optional SCL-low bus timeout enabled by defining TAXI_I2C_TARGET_TIMEOUT_EN.
module taxi_i2c_target
  import taxi_i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter int unsigned REG_COUNT      = 16,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 3125000,
  localparam int unsigned AW            = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i2c_scl_i,
  output logic          i2c_scl_o,
  input  logic          i2c_sda_i,
  output logic          i2c_sda_o,
  input  logic [AW-1:0] host_addr,
  input  logic          host_wr_en,
  input  logic [7:0]    host_wr_data,
  output logic [7:0]    host_rd_data,
  output logic          i2c_wr_valid,
  output logic [AW-1:0] i2c_wr_addr,
  output logic          bus_active,
  output logic          addressed
);

  logic w_scl;
  logic w_sda;

  taxi_i2c_target_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (i2c_scl_i),
    .o_level(w_scl)
  );

  taxi_i2c_target_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (i2c_sda_i),
    .o_level(w_sda)
  );

  logic               r_scl_prev;
  logic               r_sda_prev;
  state_e             r_state,     w_state_d;
  logic [BitCntW-1:0] r_bit_cnt,   w_bit_cnt_d;
  logic [7:0]         r_shift,     w_shift_d;
  logic [AW-1:0]      r_ptr,       w_ptr_d;
  logic               r_sda_o,     w_sda_d;
  logic               r_rw,        w_rw_d;
  logic               r_mack,      w_mack_d;
  logic               r_bus_active, w_bus_active_d;
  logic               r_addressed, w_addressed_d;
  logic [7:0]         r_regs [REG_COUNT];
  logic [7:0]         r_host_rd_data;
  logic               r_wr_valid;
  logic [AW-1:0]      r_wr_addr;
  logic               w_wr_en;
  logic [7:0]         w_rx_byte;
  logic [7:0]         w_rd_word;
  logic               w_timeout;

  wire w_scl_rise = w_scl & ~r_scl_prev;
  wire w_scl_fall = ~w_scl & r_scl_prev;
  wire w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  wire w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign w_rx_byte = {r_shift[6:0], w_sda};
  assign w_rd_word = r_regs[r_ptr];

`ifdef TAXI_I2C_TARGET_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  // Count clk cycles spent with SCL held low during a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_scl && r_bus_active) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = !w_scl && r_bus_active && (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Protocol FSM: next state, shift/pointer updates and SDA drive level.
  always_comb begin
    w_state_d      = r_state;
    w_bit_cnt_d    = r_bit_cnt;
    w_shift_d      = r_shift;
    w_ptr_d        = r_ptr;
    w_sda_d        = r_sda_o;
    w_rw_d         = r_rw;
    w_mack_d       = r_mack;
    w_bus_active_d = r_bus_active;
    w_addressed_d  = r_addressed;
    w_wr_en        = 1'b0;

    if (w_timeout) begin
      w_state_d      = StIdle;
      w_sda_d        = 1'b1;
      w_bus_active_d = 1'b0;
      w_addressed_d  = 1'b0;
    end else if (w_start) begin
      w_state_d      = StAddr;
      w_bit_cnt_d    = '0;
      w_sda_d        = 1'b1;
      w_bus_active_d = 1'b1;
      w_addressed_d  = 1'b0;
    end else if (w_stop) begin
      w_state_d      = StIdle;
      w_sda_d        = 1'b1;
      w_bus_active_d = 1'b0;
      w_addressed_d  = 1'b0;
    end else begin
      unique case (r_state)
        StAddr, StPtr, StWrData: begin
          if (w_scl_rise && r_bit_cnt != BitCntW'(8)) begin
            w_shift_d   = w_rx_byte;
            w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
            if (r_bit_cnt == BitCntW'(7)) begin
              if (r_state == StPtr) begin
                w_ptr_d = w_rx_byte[AW-1:0];
              end else if (r_state == StWrData) begin
                w_wr_en = 1'b1;
                w_ptr_d = r_ptr + AW'(1);
              end
            end
          end else if (w_scl_fall && r_bit_cnt == BitCntW'(8)) begin
            if (r_state != StAddr) begin
              w_state_d = (r_state == StPtr) ? StPtrAck : StWrAck;
              w_sda_d   = 1'b0;
            end else if (r_shift[7:1] == DEV_ADDR) begin
              w_state_d     = StAddrAck;
              w_sda_d       = 1'b0;
              w_addressed_d = 1'b1;
              w_rw_d        = r_shift[RwBit];
            end else begin
              w_state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (w_scl_fall) begin
            w_bit_cnt_d = '0;
            if (r_rw) begin
              w_state_d = StRdData;
              w_shift_d = w_rd_word;
              w_sda_d   = w_rd_word[7];
            end else begin
              w_state_d = StPtr;
              w_sda_d   = 1'b1;
            end
          end
        end
        StPtrAck, StWrAck: begin
          if (w_scl_fall) begin
            w_state_d   = StWrData;
            w_bit_cnt_d = '0;
            w_sda_d     = 1'b1;
          end
        end
        StRdData: begin
          if (w_scl_rise && r_bit_cnt != BitCntW'(8)) begin
            w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
            if (r_bit_cnt == BitCntW'(7)) begin
              w_ptr_d = r_ptr + AW'(1);
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == BitCntW'(8)) begin
              w_state_d   = StRdAck;
              w_bit_cnt_d = '0;
              w_sda_d     = 1'b1;
            end else begin
              w_shift_d = {r_shift[6:0], 1'b1};
              w_sda_d   = r_shift[6];
            end
          end
        end
        StRdAck: begin
          if (w_scl_rise) begin
            w_mack_d    = ~w_sda;
            w_bit_cnt_d = BitCntW'(1);
          end else if (w_scl_fall && r_bit_cnt == BitCntW'(1)) begin
            w_bit_cnt_d = '0;
            if (r_mack) begin
              w_state_d = StRdData;
              w_shift_d = w_rd_word;
              w_sda_d   = w_rd_word[7];
            end else begin
              w_state_d = StIgnore;
            end
          end
        end
        default: begin
          w_sda_d = 1'b1;
        end
      endcase
    end
  end

  // State and protocol registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev   <= 1'b1;
      r_sda_prev   <= 1'b1;
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_ptr        <= '0;
      r_sda_o      <= 1'b1;
      r_rw         <= 1'b0;
      r_mack       <= 1'b0;
      r_bus_active <= 1'b0;
      r_addressed  <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      r_scl_prev   <= w_scl;
      r_sda_prev   <= w_sda;
      r_state      <= w_state_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_shift      <= w_shift_d;
      r_ptr        <= w_ptr_d;
      r_sda_o      <= w_sda_d;
      r_rw         <= w_rw_d;
      r_mack       <= w_mack_d;
      r_bus_active <= w_bus_active_d;
      r_addressed  <= w_addressed_d;
      r_wr_valid   <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_ptr;
      end
    end
  end

  // Register file: an I2C write to the same index overrides a concurrent host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        r_regs[i] <= '0;
      end
      r_host_rd_data <= '0;
    end else begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        if (w_wr_en && r_ptr == AW'(i)) begin
          r_regs[i] <= w_rx_byte;
        end else if (host_wr_en && host_addr == AW'(i)) begin
          r_regs[i] <= host_wr_data;
        end
      end
      r_host_rd_data <= r_regs[host_addr];
    end
  end

  assign i2c_scl_o    = 1'b1;
  assign i2c_sda_o    = r_sda_o;
  assign host_rd_data = r_host_rd_data;
  assign i2c_wr_valid = r_wr_valid;
  assign i2c_wr_addr  = r_wr_addr;
  assign bus_active   = r_bus_active;
  assign addressed    = r_addressed;

endmodule

// File: tb/tb_taxi_i2c_target.sv
// Directed bench for taxi_i2c_target acting as an I2C initiator with open-drain SDA.
module tb_taxi_i2c_target;

  localparam int Q = 20;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic       scl_o, sda_o;
  logic [3:0] host_addr = '0;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wr_data = '0;
  logic [7:0] host_rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic       bus_active, addressed;
  logic       sda_line;

  int total = 0;
  int bad = 0;
  logic [7:0] model [16];
  logic [3:0] exp_wr_q [$];
  logic [7:0] exp_rd_q [$];

  always #5 clk = ~clk;
  assign sda_line = tb_sda & sda_o;

  taxi_i2c_target #(
    .DEV_ADDR      (7'h50),
    .REG_COUNT     (16),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i2c_scl_i   (tb_scl),
    .i2c_scl_o   (scl_o),
    .i2c_sda_i   (sda_line),
    .i2c_sda_o   (sda_o),
    .host_addr   (host_addr),
    .host_wr_en  (host_wr_en),
    .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data),
    .i2c_wr_valid(wr_valid),
    .i2c_wr_addr (wr_addr),
    .bus_active  (bus_active),
    .addressed   (addressed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for I2C-committed writes.
  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      if (exp_wr_q.size() == 0) check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
      else check("wr_addr", 32'(wr_addr), 32'(exp_wr_q.pop_front()));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; idle(Q);
    tb_scl = 1'b1; idle(Q);
    tb_sda = 1'b0; idle(Q);
    tb_scl = 1'b0; idle(Q);
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; idle(Q);
    tb_scl = 1'b1; idle(Q);
    tb_sda = 1'b1; idle(Q);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input bit glitch, input bit clash);
    for (int i = 0; i < n; i++) begin
      tb_sda = d[7-i]; idle(Q);
      tb_scl = 1'b1;
      if (glitch && i == 0) begin
        idle(Q);
        tb_sda = ~tb_sda; @(negedge clk);
        tb_sda = ~tb_sda; idle(Q - 1);
      end else if (clash && i == 7) begin
        host_addr = 4'd4; host_wr_data = 8'h22; host_wr_en = 1'b1;
        for (int k = 0; k < 2 * Q; k++) begin
          @(negedge clk);
          if (wr_valid) host_wr_en = 1'b0;
        end
        host_wr_en = 1'b0;
      end else begin
        idle(2 * Q);
      end
      tb_scl = 1'b0; idle(Q);
    end
  endtask

  task automatic ack_clk(output bit ack);
    tb_sda = 1'b1; idle(Q);
    tb_scl = 1'b1; idle(Q);
    ack = (sda_line == 1'b0); idle(Q);
    tb_scl = 1'b0; idle(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack, input bit glitch = 0,
                            input bit clash = 0);
    send_bits(d, 8, glitch, clash);
    ack_clk(ack);
  endtask

  task automatic read_check(input string tag, input bit nack);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      tb_sda = 1'b1; idle(Q);
      tb_scl = 1'b1; idle(Q);
      d[7-i] = sda_line; idle(Q);
      tb_scl = 1'b0; idle(Q);
    end
    tb_sda = nack; idle(Q);
    tb_scl = 1'b1; idle(2 * Q);
    tb_scl = 1'b0; idle(Q);
    tb_sda = 1'b1;
    check(tag, 32'(d), 32'(exp_rd_q.pop_front()));
  endtask

  task automatic host_read_check(input string tag, input logic [3:0] idx);
    @(negedge clk) host_addr = idx;
    @(negedge clk);
    check(tag, 32'(host_rd_data), 32'(model[idx]));
  endtask

  task automatic host_write(input logic [3:0] idx, input logic [7:0] d);
    @(negedge clk) begin host_addr = idx; host_wr_data = d; host_wr_en = 1'b1; end
    @(negedge clk) host_wr_en = 1'b0;
    model[idx] = d;
  endtask

  initial begin
    bit ack;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    idle(3);
    check("rst_sda_o", 32'(sda_o), 1);
    check("rst_scl_o", 32'(scl_o), 1);
    check("rst_bus_active", 32'(bus_active), 0);
    check("rst_addressed", 32'(addressed), 0);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_host_rd", 32'(host_rd_data), 0);
    rst_n = 1'b1;
    idle(10);

    // Write burst at pointer 3.
    i2c_start();
    write_byte(8'hA0, ack); check("t1_addr_ack", 32'(ack), 1);
    check("t1_addressed", 32'(addressed), 1);
    check("t1_bus_active", 32'(bus_active), 1);
    write_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 1);
    exp_wr_q.push_back(4'd3); model[3] = 8'hA5;
    write_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 1);
    exp_wr_q.push_back(4'd4); model[4] = 8'h5A;
    write_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 1);
    i2c_stop(); idle(10);
    check("t1_bus_idle", 32'(bus_active), 0);
    check("t1_addr_clr", 32'(addressed), 0);
    host_read_check("t1_reg3", 4'd3);
    host_read_check("t1_reg4", 4'd4);
    check("t1_wr_drained", 32'(exp_wr_q.size()), 0);

    // Random read across the wrap point.
    host_write(4'd15, 8'hC3);
    host_write(4'd0, 8'h3C);
    i2c_start();
    write_byte(8'hA0, ack); check("t2_addr_ack", 32'(ack), 1);
    write_byte(8'h0F, ack); check("t2_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'hA1, ack); check("t2_raddr_ack", 32'(ack), 1);
    exp_rd_q.push_back(model[15]); read_check("t2_rd15", 1'b0);
    exp_rd_q.push_back(model[0]);  read_check("t2_rd0", 1'b1);
    check("t2_sda_released", 32'(sda_o), 1);
    i2c_stop(); idle(10);

    // Foreign address is ignored, then a normal write.
    i2c_start();
    write_byte(8'hA2, ack); check("t3_no_ack", 32'(ack), 0);
    check("t3_not_addressed", 32'(addressed), 0);
    check("t3_bus_active", 32'(bus_active), 1);
    write_byte(8'h00, ack); check("t3_no_ack2", 32'(ack), 0);
    i2c_stop(); idle(10);
    host_read_check("t3_reg0", 4'd0);
    i2c_start();
    write_byte(8'hA0, ack); check("t3_addr_ack", 32'(ack), 1);
    write_byte(8'h05, ack);
    exp_wr_q.push_back(4'd5); model[5] = 8'h11;
    write_byte(8'h11, ack); check("t3_d_ack", 32'(ack), 1);
    i2c_stop(); idle(10);
    host_read_check("t3_reg5", 4'd5);

    // STOP in the middle of a data byte.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h06, ack);
    send_bits(8'hFF, 4, 1'b0, 1'b0);
    i2c_stop(); idle(10);
    check("t4_sda", 32'(sda_o), 1);
    check("t4_bus_idle", 32'(bus_active), 0);
    host_read_check("t4_reg6", 4'd6);
    check("t4_no_write", 32'(exp_wr_q.size()), 0);

    // Reset asserted while the target drives a read bit.
    host_write(4'd2, 8'h0F);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    i2c_start();
    write_byte(8'hA1, ack); check("t5_raddr_ack", 32'(ack), 1);
    check("t5_sda_driven", 32'(sda_o), 0);
    #2 rst_n = 1'b0;
    #1 check("t5_sda_async", 32'(sda_o), 1);
    tb_scl = 1'b1; tb_sda = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    idle(5);
    rst_n = 1'b1;
    idle(10);
    check("t5_bus_idle", 32'(bus_active), 0);
    host_write(4'd0, 8'h99);
    host_write(4'd2, 8'h42);
    i2c_start();
    write_byte(8'hA1, ack); check("t5_addr_ack", 32'(ack), 1);
    exp_rd_q.push_back(model[0]); read_check("t5_ptr_zero", 1'b1);
    i2c_stop(); idle(10);

    // Glitches are filtered; I2C write beats a same-cycle host write.
    @(negedge clk) tb_sda = 1'b0;
    @(negedge clk) tb_sda = 1'b1;
    idle(20);
    check("t6_no_start", 32'(bus_active), 0);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h04, ack);
    exp_wr_q.push_back(4'd4); model[4] = 8'h77;
    write_byte(8'h77, ack, 1'b1, 1'b1); check("t6_d_ack", 32'(ack), 1);
    check("t6_no_stop", 32'(bus_active), 1);
    i2c_stop(); idle(10);
    host_read_check("t6_reg4", 4'd4);

    // SCL held low mid-byte.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    send_bits(8'hF0, 3, 1'b0, 1'b0);
    idle(1100);
`ifdef TAXI_I2C_TARGET_TIMEOUT_EN
    check("t7_bus_timeout", 32'(bus_active), 0);
    check("t7_sda", 32'(sda_o), 1);
    send_bits(8'h80, 5, 1'b0, 1'b0);
    ack_clk(ack); check("t7_no_ack", 32'(ack), 0);
`else
    check("t7_bus_held", 32'(bus_active), 1);
    exp_wr_q.push_back(4'd1); model[1] = 8'hF0;
    send_bits(8'h80, 5, 1'b0, 1'b0);
    ack_clk(ack); check("t7_ack", 32'(ack), 1);
`endif
    i2c_stop(); idle(20);
    host_read_check("t7_reg1", 4'd1);
    check("end_wr_drained", 32'(exp_wr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxi_i2c_target.md
Name: taxi_i2c_target

Overview:
- I2C target (responder) for the bus driven by the team's XFCP I2C master. It exposes a small byte-wide register file to an external I2C initiator.
- Supports 7-bit addressing, an 8-bit register pointer that auto-increments, write bursts and read bursts (random read via repeated START).
- A local-side port lets fabric logic read and write the same register file.
- Sits in fpga_core-style top levels, for example to emulate an SFP EEPROM or board-management target in loopback tests.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address this block responds to.
- REG_COUNT, 16, register file depth in bytes; must be a power of two, 2 to 256.
- FILTER_LEN, 4, number of consecutive equal samples before a filtered SCL/SDA level changes.
- TIMEOUT_CYCLES, 3125000, SCL-low timeout in clk cycles (25 ms at 125 MHz); used only with the optional feature.

Ports:
- clk  input  1  block clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- i2c_scl_i  input  1  SCL pin sample.
- i2c_scl_o  output  1  SCL drive; 1 = released. Always 1: no clock stretching.
- i2c_sda_i  input  1  SDA pin sample.
- i2c_sda_o  output  1  SDA drive; 0 pulls low, 1 releases.
- host_addr  input  $clog2(REG_COUNT)  local register index.
- host_wr_en  input  1  local write strobe.
- host_wr_data  input  8  local write data.
- host_rd_data  output  8  contents of host_addr, registered (1-cycle latency).
- i2c_wr_valid  output  1  one-cycle pulse on each register write committed from I2C.
- i2c_wr_addr  output  $clog2(REG_COUNT)  index of that write.
- bus_active  output  1  high from START to STOP (any address).
- addressed  output  1  high from an ACKed address byte to STOP or repeated START.

Behaviour:
- Reset values: i2c_sda_o=1, i2c_scl_o=1, host_rd_data=0, i2c_wr_valid=0, i2c_wr_addr=0, bus_active=0, addressed=0. Register file = 0, pointer = 0, state = IDLE. Reset takes effect asynchronously and releases SDA immediately.
- Input conditioning: 2-FF synchronizer followed by the glitch filter. Filter outputs reset to 1. Edge detection runs on the filtered levels.
- START: filtered SDA 1->0 while SCL=1. STOP: filtered SDA 0->1 while SCL=1. Both are honoured in every state, including mid-byte. START and repeated START go to ADDR with bit count 0. STOP goes to IDLE and releases SDA.
- Bits are sampled on SCL rising edges, MSB first. SDA is changed only on SCL falling edges.
- States:
  - IDLE
  - ADDR: 8 bits shifted in. On a match with DEV_ADDR go to ADDR_ACK; otherwise go to IGNORE until the next START or STOP.
  - ADDR_ACK: SDA=0 for one SCL high period. R/W=0 goes to PTR; R/W=1 goes to RD_DATA.
  - PTR: byte shifted in; pointer = byte[$clog2(REG_COUNT)-1:0]. Then PTR_ACK, then WR_DATA.
  - WR_DATA: byte shifted in. On the 8th rising edge, write reg[pointer], pulse i2c_wr_valid, advance the pointer. Then WR_ACK (drive 0), then back to WR_DATA.
  - RD_DATA: the shift register loads reg[pointer] on the falling edge that ends the ACK. Bits drive SDA (0 = pull low, 1 = release). The pointer advances after the 8th bit. Then RD_ACK releases SDA and samples the master's ACK/NACK. ACK returns to RD_DATA; NACK goes to IGNORE.
- The pointer wraps modulo REG_COUNT. It persists across transactions (random read = write pointer, repeated START, read) and resets only on rst_n.
- Same-cycle I2C and host writes to the same index: the I2C write wins. Different indices: both commit.
- A read byte is a snapshot taken at load time. Host writes during shifting do not affect that byte.
- host_rd_data reflects writes made in the previous cycle (read-after-write, 1-cycle).
- Address ACK latency: SDA is driven low within FILTER_LEN+3 clk cycles of the SCL falling edge that ends bit 8.

Optional Feature:
- Macro: TAXI_I2C_TARGET_TIMEOUT_EN.
- Defined: a counter increments while filtered SCL=0 and bus_active=1, and clears when SCL=1. When it reaches TIMEOUT_CYCLES, the block releases SDA, goes to IDLE, and clears bus_active and addressed. A partially shifted write byte is discarded.
- Undefined: there is no counter. The block waits indefinitely for SCL, START or STOP.

Decomposition:
- Package taxi_i2c_target_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - a localparam for the bit-counter width;
  - the R/W bit position constant.
- Sub-module taxi_i2c_target_filter: 2-FF synchronizer plus a FILTER_LEN-sample glitch filter, one bit wide, instantiated for SCL and for SDA, with the same clk/rst_n.

Test Plan:
- Write 0x50/W, pointer 0x03, data 0xA5, 0x5A, STOP -> reg[3]=0xA5, reg[4]=0x5A; two i2c_wr_valid pulses with addresses 3 and 4; all three bytes ACKed.
- Random read: 0x50/W, pointer 0x0F, repeated START, 0x50/R, read 2 bytes (ACK then NACK) -> returns reg[15] then reg[0] (wrap); SDA released after NACK.
- Address 0x51 -> no ACK (SDA stays 1), addressed=0, no register change; the next 0x50 transaction works.
- STOP injected after 4 data bits of a write -> no write, IDLE, SDA released. Assert rst_n low mid-read -> SDA=1 immediately and the pointer returns to 0.
- 1-cycle SDA glitch while SCL=1 (FILTER_LEN=4) -> no START/STOP detected. Host write to index 4 in the same cycle as an I2C write of 0x77 to index 4 -> reg[4]=0x77.
- With TAXI_I2C_TARGET_TIMEOUT_EN and TIMEOUT_CYCLES=1000: hold SCL low 1000 cycles mid-byte -> bus_active=0, SDA=1. Without the macro -> state is retained.
